// File: rtl/rv_alu_mc_if.sv
// Request/response channel between the execute stage and rv_alu_mc.
// Both directions use a valid/ready handshake.
interface rv_alu_mc_if #(
   parameter int XLEN = 32
);
   logic            req_valid_i;
   logic            req_ready_o;
   logic [XLEN-1:0] opr_a_i;
   logic [XLEN-1:0] opr_b_i;
   logic [4:0]      op_i;
   logic            resp_valid_o;
   logic            resp_ready_i;
   logic [XLEN-1:0] alu_res_o;
   logic            busy_o;

   modport slave (
      input  req_valid_i, opr_a_i, opr_b_i, op_i, resp_ready_i,
      output req_ready_o, resp_valid_o, alu_res_o, busy_o
   );

   modport master (
      output req_valid_i, opr_a_i, opr_b_i, op_i, resp_ready_i,
      input  req_ready_o, resp_valid_o, alu_res_o, busy_o
   );
endinterface

// File: rtl/rv_alu_mc.sv
// Multi-cycle RV ALU: single-cycle base ops, iterative M-extension
// (1-bit/cycle shift-add multiply and restoring divide).
module rv_alu_mc #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       flush_i,
   rv_alu_mc_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      ST_IDLE, ST_MUL, ST_DIV, ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]   res_q, res_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opd_q, opd_d;
   logic              neg_q, neg_d;
   logic              negr_q, negr_d;
   logic              sel_q, sel_d;
   logic              spc_q, spc_d;

   logic [XLEN-1:0]    a, b, base_res;
   logic [4:0]         op;
   logic [SHAMT_W-1:0] shamt;

   assign a     = bus.opr_a_i;
   assign b     = bus.opr_b_i;
   assign op    = bus.op_i;
   assign shamt = b[SHAMT_W-1:0];

   always_comb begin
      base_res = '0;
      case (op)
         5'd0:    base_res = a + b;
         5'd1:    base_res = a - b;
         5'd2:    base_res = a << shamt;
         5'd3:    base_res = a >> shamt;
         5'd4:    base_res = $signed(a) >>> shamt;
         5'd5:    base_res = a | b;
         5'd6:    base_res = a & b;
         5'd7:    base_res = a ^ b;
         5'd8:    base_res = XLEN'(a < b);
         5'd9:    base_res = XLEN'($signed(a) < $signed(b));
         5'd10:   base_res = XLEN'(a == b);
         5'd11:   base_res = XLEN'($signed(a) >= $signed(b));
         5'd12:   base_res = XLEN'(a >= b);
         default: base_res = '0;
      endcase
   end

   logic            is_m, is_div, a_sgn, b_sgn;
   logic            a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, spc_res;

   assign is_m   = (op[4:3] == 2'b10);
   assign is_div = op[2];
   assign a_sgn  = is_div ? ~op[0] : (op[1:0] != 2'b11);
   assign b_sgn  = is_div ? ~op[0] : ~op[1];
   assign a_neg  = a_sgn & a[XLEN-1];
   assign b_neg  = b_sgn & b[XLEN-1];
   assign a_mag  = a_neg ? -a : a;
   assign b_mag  = b_neg ? -b : b;

   assign div_zero = (b == '0);
   assign div_ovf  = ~op[0] & (&b) &
                     (a == {1'b1, {(XLEN-1){1'b0}}});
   assign spc_res  = op[1] ? (div_zero ? a : '0)
                           : (div_zero ? '1 : a);

   // Multiplier lives in acc_q low half and shifts out as the product
   // accumulates into the high half.
   logic [XLEN:0]     msum;
   logic [2*XLEN-1:0] mstep, mfix;

   assign msum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opd_q} : '0);
   assign mstep = {msum, acc_q[XLEN-1:1]};
   assign mfix  = neg_q ? -mstep : mstep;

   // Remainder in the high half, dividend bits shift out of the low half
   // while quotient bits shift in.
   logic [XLEN:0]     dt;
   logic [XLEN+1:0]   ddiff;
   logic              qbit;
   logic [2*XLEN-1:0] dstep;
   logic [XLEN-1:0]   dq, dr, qfix, rfix;

   assign dt    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
   assign ddiff = {1'b0, dt} - {2'b00, opd_q};
   assign qbit  = ~ddiff[XLEN+1];
   assign dstep = {qbit ? ddiff[XLEN-1:0] : dt[XLEN-1:0],
                   acc_q[XLEN-2:0], qbit};
   assign dq    = dstep[XLEN-1:0];
   assign dr    = dstep[2*XLEN-1:XLEN];
   assign qfix  = neg_q ? -dq : dq;
   assign rfix  = negr_q ? -dr : dr;

   logic last, accept;

   assign last   = (cnt_q == CW'(XLEN-1));
   assign accept = bus.req_valid_i & ~flush_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      acc_d   = acc_q;
      opd_d   = opd_q;
      neg_d   = neg_q;
      negr_d  = negr_q;
      sel_d   = sel_q;
      spc_d   = spc_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cnt_d = '0;
               neg_d = a_neg ^ b_neg;
               if (is_m && !is_div) begin
                  acc_d   = {{XLEN{1'b0}}, b_mag};
                  opd_d   = a_mag;
                  sel_d   = (op[1:0] != 2'b00);
                  state_d = ST_MUL;
               end else if (is_m) begin
                  acc_d   = {{XLEN{1'b0}}, a_mag};
                  opd_d   = b_mag;
                  negr_d  = a_neg;
                  sel_d   = op[1];
                  spc_d   = div_zero | div_ovf;
                  if (div_zero | div_ovf) res_d = spc_res;
                  state_d = ST_DIV;
               end else begin
                  res_d   = base_res;
                  state_d = ST_DONE;
               end
            end
         end
         ST_MUL: begin
            acc_d = mstep;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               res_d   = sel_q ? mfix[2*XLEN-1:XLEN] : mfix[XLEN-1:0];
               state_d = ST_DONE;
            end
         end
         ST_DIV: begin
            acc_d = dstep;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               if (!spc_q) res_d = sel_q ? rfix : qfix;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
         acc_q   <= '0;
         opd_q   <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
         sel_q   <= 1'b0;
         spc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         acc_q   <= acc_d;
         opd_q   <= opd_d;
         neg_q   <= neg_d;
         negr_q  <= negr_d;
         sel_q   <= sel_d;
         spc_q   <= spc_d;
      end
   end

   assign bus.req_ready_o  = (state_q == ST_IDLE) & ~flush_i;
   assign bus.resp_valid_o = (state_q == ST_DONE);
   assign bus.alu_res_o    = res_q;
   assign bus.busy_o       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_rv_alu_mc.sv
// Self-checking bench for rv_alu_mc: directed corner cases plus
// randomized ops against a native-arithmetic reference model.
module tb_rv_alu_mc;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;
   logic f64   = 1'b0;

   always #5 clk = ~clk;

   rv_alu_mc_if #(.XLEN(32)) b32 ();
   rv_alu_mc_if #(.XLEN(64)) b64 ();

   rv_alu_mc #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (flush),
      .bus     (b32)
   );

   rv_alu_mc #(.XLEN(64)) dut64 (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .flush_i (f64),
      .bus     (b64)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [4:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      int          sa, sb;
      logic [4:0]  sh;
      logic [63:0] ea, eb, ua, ub, p;
      sa = a;
      sb = b;
      sh = b[4:0];
      ea = {{32{a[31]}}, a};
      eb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a << sh;
         5'd3:  return a >> sh;
         5'd4:  return sa >>> sh;
         5'd5:  return a | b;
         5'd6:  return a & b;
         5'd7:  return a ^ b;
         5'd8:  return {31'b0, a < b};
         5'd9:  return {31'b0, sa < sb};
         5'd10: return {31'b0, a == b};
         5'd11: return {31'b0, sa >= sb};
         5'd12: return {31'b0, a >= b};
         5'd16: begin p = ea * eb; return p[31:0]; end
         5'd17: begin p = ea * eb; return p[63:32]; end
         5'd18: begin p = ea * ub; return p[63:32]; end
         5'd19: begin p = ua * ub; return p[63:32]; end
         5'd20: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         5'd21: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
            return sa % sb;
         end
         5'd23: return (b == 0) ? a : a % b;
         default: return 0;
      endcase
   endfunction

   function automatic int explat(input logic [4:0] op, input int xl);
      return (op >= 16 && op <= 23) ? xl + 1 : 1;
   endfunction

   task automatic accept32(input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      @(negedge clk);
      b32.req_valid_i = 1'b1;
      b32.op_i        = op;
      b32.opr_a_i     = a;
      b32.opr_b_i     = b;
      @(posedge clk);
      #1 b32.req_valid_i = 1'b0;
   endtask

   task automatic wait32(output int lat);
      lat = 0;
      while (lat < 200) begin
         @(negedge clk);
         lat++;
         if (b32.resp_valid_o) break;
      end
   endtask

   task automatic consume32();
      b32.resp_ready_i = 1'b1;
      @(posedge clk);
      #1 b32.resp_ready_i = 1'b0;
   endtask

   task automatic run32(input string tag, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
      int lat;
      accept32(op, a, b);
      wait32(lat);
      chk({tag, "_lat"}, 64'(lat), 64'(explat(op, 32)));
      chk({tag, "_res"}, 64'(b32.alu_res_o), 64'(exp));
      consume32();
   endtask

   task automatic run64(input string tag, input logic [4:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp);
      int lat;
      @(negedge clk);
      b64.req_valid_i = 1'b1;
      b64.op_i        = op;
      b64.opr_a_i     = a;
      b64.opr_b_i     = b;
      @(posedge clk);
      #1 b64.req_valid_i = 1'b0;
      lat = 0;
      while (lat < 300) begin
         @(negedge clk);
         lat++;
         if (b64.resp_valid_o) break;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(explat(op, 64)));
      chk({tag, "_res"}, b64.alu_res_o, exp);
      b64.resp_ready_i = 1'b1;
      @(posedge clk);
      #1 b64.resp_ready_i = 1'b0;
   endtask

   initial begin
      int          lat, seen;
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [63:0] a6, b6;
      logic [127:0] p6;

      b32.req_valid_i  = 1'b0;
      b32.resp_ready_i = 1'b0;
      b32.op_i         = '0;
      b32.opr_a_i      = '0;
      b32.opr_b_i      = '0;
      b64.req_valid_i  = 1'b0;
      b64.resp_ready_i = 1'b0;
      b64.op_i         = '0;
      b64.opr_a_i      = '0;
      b64.opr_b_i      = '0;

      #12;
      chk("rst_ready", 64'(b32.req_ready_o), 64'd1);
      chk("rst_valid", 64'(b32.resp_valid_o), 64'd0);
      chk("rst_res", 64'(b32.alu_res_o), 64'd0);
      chk("rst_busy", 64'(b32.busy_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run32("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0);
      run32("sra", 5'd4, 32'h8000_0000, 32'd4, 32'hF800_0000);
      run32("sll_mask", 5'd2, 32'd1, 32'd33, 32'd2);
      run32("slt", 5'd9, 32'hFFFF_FFFF, 32'd1, 32'd1);
      run32("sltu", 5'd8, 32'hFFFF_FFFF, 32'd1, 32'd0);
      run32("sge", 5'd11, 32'd5, 32'd5, 32'd1);
      run32("illegal", 5'd13, 32'd7, 32'd9, 32'd0);
      run32("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
      run32("mul", 5'd16, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB);
      run32("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF);
      run32("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run32("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
      run32("div_neg", 5'd20, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run32("rem_neg", 5'd22, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run32("divu_z", 5'd21, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run32("remu_z", 5'd23, 32'd5, 32'd0, 32'd5);

      accept32(5'd16, 32'd3, 32'd5);
      wait32(lat);
      chk("bp_lat", 64'(lat), 64'd33);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("bp_valid%0d", i), 64'(b32.resp_valid_o), 64'd1);
         chk($sformatf("bp_res%0d", i), 64'(b32.alu_res_o), 64'd15);
         chk($sformatf("bp_rdy%0d", i), 64'(b32.req_ready_o), 64'd0);
      end
      @(negedge clk);
      consume32();
      @(negedge clk);
      chk("bp_after_valid", 64'(b32.resp_valid_o), 64'd0);
      chk("bp_after_ready", 64'(b32.req_ready_o), 64'd1);

      accept32(5'd20, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      chk("fl_busy", 64'(b32.busy_o), 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("fl_valid", 64'(b32.resp_valid_o), 64'd0);
      chk("fl_ready", 64'(b32.req_ready_o), 64'd1);
      chk("fl_idle", 64'(b32.busy_o), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (b32.resp_valid_o) seen++;
      end
      chk("fl_noresp", 64'(seen), 64'd0);

      @(negedge clk);
      b32.req_valid_i = 1'b1;
      b32.op_i        = 5'd0;
      flush           = 1'b1;
      @(posedge clk);
      #1;
      b32.req_valid_i = 1'b0;
      flush           = 1'b0;
      @(negedge clk);
      chk("flreq_busy", 64'(b32.busy_o), 64'd0);
      chk("flreq_valid", 64'(b32.resp_valid_o), 64'd0);

      accept32(5'd16, 32'd9, 32'd9);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_ready", 64'(b32.req_ready_o), 64'd1);
      chk("mrst_valid", 64'(b32.resp_valid_o), 64'd0);
      chk("mrst_res", 64'(b32.alu_res_o), 64'd0);
      chk("mrst_busy", 64'(b32.busy_o), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (b32.resp_valid_o) seen++;
      end
      chk("mrst_noresp", 64'(seen), 64'd0);

      for (int i = 0; i < 80; i++) begin
         op = 5'($urandom_range(0, 31));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(0, 40));
            default: ;
         endcase
         run32($sformatf("rnd%0d_op%0d", i, op), op, a, b,
               model(op, a, b));
      end

      run64("m64_mulhu", 5'd19, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE);
      for (int i = 0; i < 4; i++) begin
         a6 = {$urandom, $urandom};
         b6 = {$urandom, $urandom};
         p6 = {64'b0, a6} * {64'b0, b6};
         run64($sformatf("r64_mulhu%0d", i), 5'd19, a6, b6, p6[127:64]);
         b6 = b6 >> $urandom_range(0, 60);
         run64($sformatf("r64_divu%0d", i), 5'd21, a6, b6,
               (b6 == 0) ? '1 : a6 / b6);
         run64($sformatf("r64_add%0d", i), 5'd0, a6, b6, a6 + b6);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rv_alu_mc.md
Name: rv_alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU.
- Executes all base integer ALU ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at XLEN width.
- Sits in the execute stage behind a valid/ready request channel and returns results on a valid/ready response channel.
- Base ops complete in 1 cycle; multiply and divide iterate 1 bit/cycle.

Parameters:
XLEN, 32, operand/result width (32 or 64)
SHAMT_W, $clog2(XLEN), shift-amount bits taken from opr_b_i

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  abort in-flight op, discard any pending response
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when req_valid_i & req_ready_o
opr_a_i  in  XLEN  operand A
opr_b_i  in  XLEN  operand B
op_i  in  5  operation code
resp_valid_o  out  1  result valid
resp_ready_i  in  1  consumer accepts result
alu_res_o  out  XLEN  result
busy_o  out  1  state != IDLE

Behaviour:
- One clock; reset is asynchronous and active-low, on rst_ni.
- Reset: state=IDLE, req_ready_o=1, resp_valid_o=0, alu_res_o=0, busy_o=0, counter=0.
- op_i codes:
  - Base: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 OR, 6 AND, 7 XOR, 8 SLTU, 9 SLT, 10 EQL, 11 SGE (signed >=), 12 UGE (unsigned >=).
  - M-ext: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: treated as a base op, result 0.
- Shifts use opr_b_i[SHAMT_W-1:0]. Compare ops return {XLEN-1 zeros, flag}. Arithmetic wraps modulo 2^XLEN.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: req_ready_o=1. On accept:
    - base op: result computed combinationally and registered -> DONE.
    - MUL*: latch operand magnitudes and result-sign flag per signedness (MULHSU: A signed, B unsigned) -> MUL.
    - DIV*: latch magnitudes and sign flags -> DIV.
  - MUL: shift-add of 2*XLEN product, counter 0..XLEN-1. At counter==XLEN-1 -> DONE; negate product if sign flag set. MUL returns low XLEN bits, MULH/MULHSU/MULHU return high XLEN bits.
  - DIV: restoring division, one quotient bit/cycle, XLEN cycles -> DONE. Sign fix: quotient negative iff signs differ; remainder takes the dividend sign.
  - DONE: resp_valid_o=1, alu_res_o stable. When resp_ready_i=1 -> IDLE. Result and valid are held indefinitely under backpressure.
- req_ready_o=1 only in IDLE. No new request is accepted in the same cycle a response is consumed.
- Latency (accept edge N):
  - base: resp_valid_o high from cycle N+1.
  - mul/div: resp_valid_o high from cycle N+XLEN+1.
- Divide corner cases (resolved at accept; still take the full XLEN+1 latency for uniform timing):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (A = most-negative, B = -1): DIV = A; REM = 0.
- flush_i: highest priority after reset. In any state -> IDLE next cycle; resp_valid_o=0 next cycle; counter cleared. A request presented in the same cycle as flush_i is not accepted.
- Reset mid-operation: immediate return to reset values; no response produced.
- busy_o = (state != IDLE).

Test Plan:
- ADD with A=32'hFFFF_FFFF, B=1 -> alu_res_o=0, resp_valid_o exactly 1 cycle after accept. SRA with A=32'h8000_0000, B=4 -> 32'hF800_0000.
- MULHU with A=B=32'hFFFF_FFFF -> 32'hFFFF_FFFE at cycle N+33. MUL with A=-3, B=7 -> 32'hFFFF_FFEB. MULHSU with A=-1, B=2 -> 32'hFFFF_FFFF.
- DIV with A=32'h8000_0000, B=32'hFFFF_FFFF -> 32'h8000_0000. REM with the same operands -> 0. DIV with A=-7, B=2 -> -3. REM with A=-7, B=2 -> -1.
- DIVU with A=5, B=0 -> 32'hFFFF_FFFF. REMU with A=5, B=0 -> 5. Both at N+33.
- Backpressure: resp_ready_i held low 5 cycles after DONE -> alu_res_o and resp_valid_o stable, req_ready_o=0 throughout; the handshake completes on the 6th cycle.
- flush_i asserted at iteration 10 of DIV -> no response, req_ready_o=1 the next cycle. rst_ni pulsed low mid-MUL -> all outputs return to reset values asynchronously. XLEN=64 build: MULHU with A=B=all ones -> 64'hFFFF_FFFF_FFFF_FFFE at N+65.
